// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use/RAW stalls and jump flushes.
// Build option: define HAZARD_FORWARDING_EN to enable MEM/WB forwarding with one-cycle load-use stalls.
package hazard_pkg;
    typedef enum logic [1:0] {
        FW_SRC_NONE = 2'b00,
        FW_SRC_MEM  = 2'b01,
        FW_SRC_WB   = 2'b10
    } forward_source_e;
endpackage

module hazard_controller
    import hazard_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_uses_rs1_i,
    input  logic            id_uses_rs2_i,
    input  logic [4:0]      ex_rs1_addr_i,
    input  logic [4:0]      ex_rs2_addr_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            ex_reg_write_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_jump_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic            mem_reg_write_i,
    input  logic [4:0]      wb_rd_addr_i,
    input  logic            wb_reg_write_i,
    output forward_source_e rs1_forward_source_o,
    output forward_source_e rs2_forward_source_o,
    output logic            stall_o,
    output logic            bubble_ex_o,
    output logic            flush_id_o,
    output logic [15:0]     stall_count_o
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e      state_q, state_d;
    logic [1:0]  depth_q, depth_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]  hazard_depth;

    function automatic logic producer_match(input logic we, input logic [4:0] rd,
                                            input logic [4:0] r);
        return we && (rd != 5'd0) && (rd == r);
    endfunction

    function automatic logic id_match(input logic we, input logic [4:0] rd,
                                      input logic use1, input logic [4:0] r1,
                                      input logic use2, input logic [4:0] r2);
        return (use1 && producer_match(we, rd, r1)) || (use2 && producer_match(we, rd, r2));
    endfunction

`ifdef HAZARD_FORWARDING_EN
    function automatic forward_source_e fwd_sel(input logic [4:0] r, input logic [4:0] mem_rd,
                                                input logic mem_we, input logic [4:0] wb_rd,
                                                input logic wb_we);
        if (producer_match(mem_we, mem_rd, r)) return FW_SRC_MEM;
        if (producer_match(wb_we, wb_rd, r))   return FW_SRC_WB;
        return FW_SRC_NONE;
    endfunction

    always_comb begin
        rs1_forward_source_o = FW_SRC_NONE;
        rs2_forward_source_o = FW_SRC_NONE;
        if (!rst_i) begin
            rs1_forward_source_o = fwd_sel(ex_rs1_addr_i, mem_rd_addr_i, mem_reg_write_i,
                                           wb_rd_addr_i, wb_reg_write_i);
            rs2_forward_source_o = fwd_sel(ex_rs2_addr_i, mem_rd_addr_i, mem_reg_write_i,
                                           wb_rd_addr_i, wb_reg_write_i);
        end
    end

    // Only a load in EX cannot be forwarded in time; one bubble lets it reach MEM.
    always_comb begin
        hazard_depth = 2'd0;
        if (ex_mem_read_i && id_match(ex_reg_write_i, ex_rd_addr_i, id_uses_rs1_i,
                                      id_rs1_addr_i, id_uses_rs2_i, id_rs2_addr_i)) begin
            hazard_depth = 2'd1;
        end
    end
`else
    logic ex_hit, mem_hit, wb_hit;
    logic unused_inputs;

    assign rs1_forward_source_o = FW_SRC_NONE;
    assign rs2_forward_source_o = FW_SRC_NONE;
    assign unused_inputs = ^{ex_rs1_addr_i, ex_rs2_addr_i, ex_mem_read_i};

    assign ex_hit  = id_match(ex_reg_write_i, ex_rd_addr_i, id_uses_rs1_i, id_rs1_addr_i,
                              id_uses_rs2_i, id_rs2_addr_i);
    assign mem_hit = id_match(mem_reg_write_i, mem_rd_addr_i, id_uses_rs1_i, id_rs1_addr_i,
                              id_uses_rs2_i, id_rs2_addr_i);
    assign wb_hit  = id_match(wb_reg_write_i, wb_rd_addr_i, id_uses_rs1_i, id_rs1_addr_i,
                              id_uses_rs2_i, id_rs2_addr_i);

    // Wait until the nearest producer has written back: EX needs 3 cycles, MEM 2, WB 1.
    always_comb begin
        hazard_depth = 2'd0;
        if (ex_hit) begin
            hazard_depth = 2'd3;
        end else if (mem_hit) begin
            hazard_depth = 2'd2;
        end else if (wb_hit) begin
            hazard_depth = 2'd1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        if (ex_jump_i) begin
            state_d = StFlush;
            depth_d = 2'd0;
        end else begin
            case (state_q)
                StRun: begin
                    if (hazard_depth != 2'd0) begin
                        state_d = StStall;
                        depth_d = hazard_depth;
                    end
                end
                StStall: begin
                    depth_d = depth_q - 2'd1;
                    if (depth_q == 2'd1) state_d = StRun;
                end
                StFlush: state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    assign stall_o       = (state_q == StStall) && !ex_jump_i;
    assign flush_id_o    = ex_jump_i && !rst_i;
    assign bubble_ex_o   = stall_o || flush_id_o;
    assign stall_count_o = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            depth_q     <= 2'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; follows HAZARD_FORWARDING_EN if defined.
module tb_hazard_controller;
    import hazard_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [4:0]      id_rs1_addr_i, id_rs2_addr_i, ex_rs1_addr_i, ex_rs2_addr_i;
    logic [4:0]      ex_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i;
    logic            id_uses_rs1_i, id_uses_rs2_i, ex_reg_write_i, ex_mem_read_i, ex_jump_i;
    logic            mem_reg_write_i, wb_reg_write_i;
    forward_source_e rs1_fwd, rs2_fwd;
    logic            stall_o, bubble_ex_o, flush_id_o;
    logic [15:0]     stall_count_o;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

`ifdef HAZARD_FORWARDING_EN
    localparam forward_source_e ExpMem = FW_SRC_MEM;
    localparam forward_source_e ExpWb  = FW_SRC_WB;
`else
    localparam forward_source_e ExpMem = FW_SRC_NONE;
    localparam forward_source_e ExpWb  = FW_SRC_NONE;
`endif

    hazard_controller dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .id_rs1_addr_i        (id_rs1_addr_i),
        .id_rs2_addr_i        (id_rs2_addr_i),
        .id_uses_rs1_i        (id_uses_rs1_i),
        .id_uses_rs2_i        (id_uses_rs2_i),
        .ex_rs1_addr_i        (ex_rs1_addr_i),
        .ex_rs2_addr_i        (ex_rs2_addr_i),
        .ex_rd_addr_i         (ex_rd_addr_i),
        .ex_reg_write_i       (ex_reg_write_i),
        .ex_mem_read_i        (ex_mem_read_i),
        .ex_jump_i            (ex_jump_i),
        .mem_rd_addr_i        (mem_rd_addr_i),
        .mem_reg_write_i      (mem_reg_write_i),
        .wb_rd_addr_i         (wb_rd_addr_i),
        .wb_reg_write_i       (wb_reg_write_i),
        .rs1_forward_source_o (rs1_fwd),
        .rs2_forward_source_o (rs2_fwd),
        .stall_o              (stall_o),
        .bubble_ex_o          (bubble_ex_o),
        .flush_id_o           (flush_id_o),
        .stall_count_o        (stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_inputs();
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
        ex_rs1_addr_i = 5'd0; ex_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
        ex_reg_write_i = 1'b0; ex_mem_read_i = 1'b0; ex_jump_i = 1'b0;
        mem_rd_addr_i = 5'd0; mem_reg_write_i = 1'b0;
        wb_rd_addr_i = 5'd0; wb_reg_write_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Load in EX writing x7, ID reads x7 via rs2: a load-use hazard and a RAW hazard on EX.
    task automatic set_ex_hazard();
        ex_rd_addr_i = 5'd7; ex_reg_write_i = 1'b1; ex_mem_read_i = 1'b1;
        id_rs2_addr_i = 5'd7; id_uses_rs2_i = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_ex_hazard();
        ex_jump_i = 1'b1; mem_rd_addr_i = 5'd5; mem_reg_write_i = 1'b1; ex_rs1_addr_i = 5'd5;
        #1;
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000", {stall_o, bubble_ex_o, flush_id_o});
        end
        checks++;
        if (rs1_fwd !== FW_SRC_NONE) begin
            errors++; $display("FAIL reset_fwd1 got %0d exp %0d", rs1_fwd, FW_SRC_NONE);
        end
        checks++;
        if (rs2_fwd !== FW_SRC_NONE) begin
            errors++; $display("FAIL reset_fwd2 got %0d exp %0d", rs2_fwd, FW_SRC_NONE);
        end
        tick();
        tick();
        checks++;
        if (stall_count_o !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got %0d exp 0", stall_count_o);
        end
        clear_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o, stall_count_o} !== {3'b000, 16'd0}) begin
            errors++; $display("FAIL reset_release got %b/%0d exp 000/0",
                               {stall_o, bubble_ex_o, flush_id_o}, stall_count_o);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        mem_rd_addr_i = 5'd5; mem_reg_write_i = 1'b1;
        wb_rd_addr_i = 5'd5; wb_reg_write_i = 1'b1; ex_rs1_addr_i = 5'd5;
        #1;
        checks++;
        if (rs1_fwd !== ExpMem) begin
            errors++; $display("FAIL fwd_mem_prio got %0d exp %0d", rs1_fwd, ExpMem);
        end
        mem_reg_write_i = 1'b0;
        #1;
        checks++;
        if (rs1_fwd !== ExpWb) begin
            errors++; $display("FAIL fwd_wb got %0d exp %0d", rs1_fwd, ExpWb);
        end
        ex_rs2_addr_i = 5'd5;
        #1;
        checks++;
        if (rs2_fwd !== ExpWb) begin
            errors++; $display("FAIL fwd_wb_rs2 got %0d exp %0d", rs2_fwd, ExpWb);
        end
        mem_rd_addr_i = 5'd0; mem_reg_write_i = 1'b1; wb_rd_addr_i = 5'd0; ex_rs2_addr_i = 5'd0;
        #1;
        checks++;
        if (rs2_fwd !== FW_SRC_NONE) begin
            errors++; $display("FAIL fwd_x0 got %0d exp %0d", rs2_fwd, FW_SRC_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_x0_and_uses();
        clear_inputs();
        id_rs1_addr_i = 5'd0; id_uses_rs1_i = 1'b1;
        ex_rd_addr_i = 5'd0; ex_reg_write_i = 1'b1; ex_mem_read_i = 1'b1;
        mem_reg_write_i = 1'b1; wb_reg_write_i = 1'b1;
        tick();
        checks++;
        if ({stall_o, bubble_ex_o} !== 2'b00) begin
            errors++; $display("FAIL x0_stall got %b exp 00", {stall_o, bubble_ex_o});
        end
        clear_inputs();
        ex_rd_addr_i = 5'd3; ex_reg_write_i = 1'b1; ex_mem_read_i = 1'b1;
        id_rs1_addr_i = 5'd3; id_rs2_addr_i = 5'd3;
        tick();
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL uses_gate got %b exp 0", stall_o);
        end
        clear_inputs();
        tick();
    endtask

`ifndef HAZARD_FORWARDING_EN
    task automatic test_raw_stall();
        clear_inputs();
        ex_rd_addr_i = 5'd3; ex_reg_write_i = 1'b1; id_rs1_addr_i = 5'd3; id_uses_rs1_i = 1'b1;
        tick();
        clear_inputs();
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b110) begin
                errors++; $display("FAIL raw_cycle%0d got %b exp 110", c,
                                   {stall_o, bubble_ex_o, flush_id_o});
            end
            tick();
        end
        exp_cnt = exp_cnt + 16'd3;
        checks++;
        if ({stall_o, stall_count_o} !== {1'b0, exp_cnt}) begin
            errors++; $display("FAIL raw_end got %b/%0d exp 0/%0d", stall_o, stall_count_o, exp_cnt);
        end
    endtask

    task automatic test_mem_depth();
        clear_inputs();
        mem_rd_addr_i = 5'd4; mem_reg_write_i = 1'b1; wb_rd_addr_i = 5'd4; wb_reg_write_i = 1'b1;
        id_rs2_addr_i = 5'd4; id_uses_rs2_i = 1'b1;
        tick();
        clear_inputs();
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (stall_o !== 1'b1) begin
                errors++; $display("FAIL mem_cycle%0d got %b exp 1", c, stall_o);
            end
            tick();
        end
        exp_cnt = exp_cnt + 16'd2;
        checks++;
        if ({stall_o, stall_count_o} !== {1'b0, exp_cnt}) begin
            errors++; $display("FAIL mem_end got %b/%0d exp 0/%0d", stall_o, stall_count_o, exp_cnt);
        end
    endtask

    task automatic test_no_reload();
        clear_inputs();
        wb_rd_addr_i = 5'd6; wb_reg_write_i = 1'b1; id_rs1_addr_i = 5'd6; id_uses_rs1_i = 1'b1;
        tick();
        wb_reg_write_i = 1'b0; ex_rd_addr_i = 5'd6; ex_reg_write_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL noreload_c1 got %b exp 1", stall_o);
        end
        tick();
        clear_inputs();
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL noreload_c2 got %b exp 0", stall_o);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({stall_o, stall_count_o} !== {1'b0, exp_cnt}) begin
            errors++; $display("FAIL noreload_end got %b/%0d exp 0/%0d", stall_o, stall_count_o,
                               exp_cnt);
        end
    endtask
`else
    task automatic test_load_use();
        clear_inputs();
        set_ex_hazard();
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL lu_pre got %b exp 0", stall_o);
        end
        tick();
        clear_inputs();
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b110) begin
            errors++; $display("FAIL lu_c1 got %b exp 110", {stall_o, bubble_ex_o, flush_id_o});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({stall_o, bubble_ex_o, stall_count_o} !== {2'b00, exp_cnt}) begin
            errors++; $display("FAIL lu_end got %b/%0d exp 00/%0d", {stall_o, bubble_ex_o},
                               stall_count_o, exp_cnt);
        end
        set_ex_hazard();
        ex_mem_read_i = 1'b0;
        tick();
        clear_inputs();
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL alu_fwd_nostall got %b exp 0", stall_o);
        end
    endtask
`endif

    task automatic test_jump_in_stall();
        clear_inputs();
`ifdef HAZARD_FORWARDING_EN
        set_ex_hazard();
        tick();
        clear_inputs();
`else
        ex_rd_addr_i = 5'd3; ex_reg_write_i = 1'b1; id_rs1_addr_i = 5'd3; id_uses_rs1_i = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL js_c1 got %b exp 1", stall_o);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
`endif
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL js_prejump got %b exp 1", stall_o);
        end
        ex_jump_i = 1'b1;
        #1;
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b011) begin
            errors++; $display("FAIL js_jump got %b exp 011", {stall_o, bubble_ex_o, flush_id_o});
        end
        tick();
        ex_jump_i = 1'b0;
        #1;
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b000) begin
            errors++; $display("FAIL js_flush got %b exp 000", {stall_o, bubble_ex_o, flush_id_o});
        end
        tick();
        checks++;
        if ({stall_o, stall_count_o} !== {1'b0, exp_cnt}) begin
            errors++; $display("FAIL js_end got %b/%0d exp 0/%0d", stall_o, stall_count_o, exp_cnt);
        end
    endtask

    task automatic test_jump_over_hazard();
        clear_inputs();
        set_ex_hazard();
        ex_jump_i = 1'b1;
        #1;
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b011) begin
            errors++; $display("FAIL jh_same got %b exp 011", {stall_o, bubble_ex_o, flush_id_o});
        end
        tick();
        ex_jump_i = 1'b0;
        #1;
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o} !== 3'b000) begin
            errors++; $display("FAIL jh_flush got %b exp 000", {stall_o, bubble_ex_o, flush_id_o});
        end
        tick();
        clear_inputs();
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL jh_masked got %b exp 0", stall_o);
        end
        tick();
        checks++;
        if ({stall_o, stall_count_o} !== {1'b0, exp_cnt}) begin
            errors++; $display("FAIL jh_cnt got %b/%0d exp 0/%0d", stall_o, stall_count_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        set_ex_hazard();
        tick();
        clear_inputs();
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL rms_pre got %b exp 1", stall_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        exp_cnt = 16'd0;
        checks++;
        if ({stall_o, bubble_ex_o, flush_id_o, stall_count_o} !== {3'b000, exp_cnt}) begin
            errors++; $display("FAIL rms_async got %b/%0d exp 000/0",
                               {stall_o, bubble_ex_o, flush_id_o}, stall_count_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if ({stall_o, stall_count_o} !== {1'b0, exp_cnt}) begin
                errors++; $display("FAIL rms_post%0d got %b/%0d exp 0/0", c, stall_o, stall_count_o);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forwarding();
        test_x0_and_uses();
`ifndef HAZARD_FORWARDING_EN
        test_raw_stall();
        test_mem_depth();
        test_no_reload();
`else
        test_load_use();
`endif
        test_jump_in_stall();
        test_jump_over_hazard();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_i in 1, rising-edge clock; rst_i in 1, asynchronous active-high reset.
REQ-002 The block SHALL have these decode-stage inputs:
- id_rs1_addr_i in 5, ID source register 1
- id_rs2_addr_i in 5, ID source register 2
- id_uses_rs1_i in 1, ID instruction reads rs1
- id_uses_rs2_i in 1, ID instruction reads rs2
REQ-003 The block SHALL have these execute-stage inputs:
- ex_rs1_addr_i in 5, EX source register 1
- ex_rs2_addr_i in 5, EX source register 2
- ex_rd_addr_i in 5, EX destination register
- ex_reg_write_i in 1, EX instruction writes rd
- ex_mem_read_i in 1, EX instruction is a load
- ex_jump_i in 1, EX redirects the PC
REQ-004 The block SHALL have these later-stage inputs:
- mem_rd_addr_i in 5, mem_reg_write_i in 1: MEM-stage producer
- wb_rd_addr_i in 5, wb_reg_write_i in 1: WB-stage producer
REQ-005 The block SHALL have these outputs:
- rs1_forward_source_o out forward_source_e, EX rs1 operand source
- rs2_forward_source_o out forward_source_e, EX rs2 operand source
- stall_o out 1, hold PC and IF/ID
- bubble_ex_o out 1, load NOP into ID/EX
- flush_id_o out 1, load NOP into IF/ID
- stall_count_o out 16, saturating count of stall cycles

Function
REQ-006 A producer stage X SHALL match a source address r only when X reg_write=1, X rd≠0 and X rd=r.
REQ-007 The FSM SHALL have three states: RUN, STALL, FLUSH; the reset state is RUN.
REQ-008 When ex_jump_i=1, the block SHALL assert flush_id_o=1 and bubble_ex_o=1 in the same cycle, hold stall_o=0, move to FLUSH, and clear the stall counter; jump has priority over every hazard.
REQ-009 FLUSH SHALL last exactly one cycle, during which hazard detection is masked (ID holds a bubble), and then return to RUN.
REQ-010 In RUN, the block SHALL detect a hazard only on a source with its id_uses_* bit set.
REQ-011 While stall_o=1, the block SHALL assert bubble_ex_o=1 and hold flush_id_o=0.
REQ-012 stall_count_o SHALL increment by one on every cycle with stall_o=1 and saturate at 16'hFFFF.
REQ-013 The forwarding outputs SHALL be combinational from the current inputs, with zero latency.
REQ-014 All state SHALL change on the rising edge of clk_i only.

Reset
REQ-015 On rst_i=1, regardless of the clock, the block SHALL enter RUN, clear the stall counter to 0 and clear stall_count_o to 0.
REQ-016 During reset, stall_o, bubble_ex_o and flush_id_o SHALL be 0.
REQ-017 During reset, both forwarding outputs SHALL be FW_SRC_NONE.
REQ-018 Reset asserted mid-STALL or mid-FLUSH SHALL abandon that sequence, with no residual stall after reset release.

Configuration
REQ-019 With HAZARD_FORWARDING_EN defined, each forwarding output SHALL select as follows:
- FW_SRC_MEM if MEM matches the EX source
- else FW_SRC_WB if WB matches the EX source
- else FW_SRC_NONE
REQ-020 With HAZARD_FORWARDING_EN defined, a load-use match (ex_mem_read_i=1 and EX matches an ID source) SHALL stall exactly one cycle: stall_o=1 and bubble_ex_o=1, STALL state, then RUN.
REQ-021 Without HAZARD_FORWARDING_EN, both forwarding outputs SHALL be constant FW_SRC_NONE.
REQ-022 Without HAZARD_FORWARDING_EN, any RAW match on an ID source SHALL load a down-counter with the largest of: 3 for an EX match, 2 for a MEM match, 1 for a WB match.
REQ-023 Without HAZARD_FORWARDING_EN, stall_o SHALL remain asserted while the counter is nonzero (STALL state), and the block SHALL return to RUN when the counter reaches 0.
REQ-024 Without HAZARD_FORWARDING_EN, no new detection SHALL reload the counter while in STALL.

Verification
REQ-025 Forward priority (EN): MEM rd=5 write, WB rd=5 write, ex_rs1=5 -> rs1_forward_source_o=FW_SRC_MEM; with MEM write=0 -> FW_SRC_WB.
REQ-026 x0 guard: MEM rd=0 write=1, ex_rs2=0 -> rs2_forward_source_o=FW_SRC_NONE; no stall for id_rs1=0 against EX rd=0.
REQ-027 Load-use (EN): ex_mem_read=1 rd=7, id_rs2=7 uses_rs2=1 -> stall_o=1 and bubble_ex_o=1 for exactly 1 cycle, stall_count_o=1.
REQ-028 Jump over hazard: a load-use condition and ex_jump_i=1 in the same cycle -> flush_id_o=1, bubble_ex_o=1, stall_o=0; the next cycle is masked (FLUSH); stall_count_o unchanged.
REQ-029 No-forward (macro off): EX rd=3 write, id_rs1=3 -> stall_o high 3 cycles, then 0; stall_count_o=3; a jump on cycle 2 -> stall drops the next cycle.
REQ-030 Reset mid-stall: assert rst_i asynchronously during STALL -> all outputs return to reset values immediately; stall_o=0 on the first post-reset edge.
